fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 139 +++++++++++++
 tb/tb_fetch_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
`timescale 1ns / 1ps
// fetch_controller
//
// Owns a single-port synchronous instruction memory and shares it between two
// users: a program loader that streams words in (LOAD), and an instruction
// fetcher that reads sequentially and handles stalls, branch redirects and halt (RUN).
//
// Ports
//   clk, rst                : clock (rising edge), asynchronous active-low reset
//   load_req                : enter program-load mode from IDLE
//   ld_valid/ld_data/ld_last: loader word stream; ld_ready accepts it in LOAD
//   start, halt, stall      : run control
//   br_taken, br_target     : fetch redirect
//   mem_en/we/addr/din      : memory port drive (combinational)
//   mem_dout                : memory read data, valid the cycle after a read
//   pc, instr, instr_valid  : fetched instruction to decode
//   busy                    : controller not in IDLE
//   load_count, load_ovf    : words accepted in the last load, write-pointer wrap flag
module fetch_controller #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              busy,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StHalted
    } state_t;

    localparam logic [ADDR_W:0]   LoadMax = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] WptrMax = '1;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [ADDR_W-1:0] wptr;
    logic              issued;

    logic              ld_accept;
    logic              fetch_rd;

    assign ld_accept = (state == StLoad) && ld_valid;
    // A redirect still issues a read that cycle; its data is simply never marked valid.
    assign fetch_rd  = (state == StRun) && !halt && (!stall || br_taken);

    assign ld_ready    = (state == StLoad);
    assign busy        = (state != StIdle);
    assign mem_en      = ld_accept || fetch_rd;
    assign mem_we      = ld_accept;
    assign mem_addr    = ld_accept ? wptr : fetch_pc[ADDR_W-1:0];
    assign mem_din     = ld_accept ? ld_data : 32'h0;
    // The memory output register holds the last read, so instr stays stable while stalled.
    assign instr       = mem_dout;
    assign instr_valid = issued;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            fetch_pc   <= RESET_PC;
            pc         <= 32'h0;
            issued     <= 1'b0;
            wptr       <= '0;
            load_count <= '0;
            load_ovf   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (load_req) begin
                        state      <= StLoad;
                        wptr       <= '0;
                        load_count <= '0;
                        load_ovf   <= 1'b0;
                    end else if (start) begin
                        state    <= StRun;
                        fetch_pc <= RESET_PC;
                    end
                end
                StLoad: begin
                    if (ld_valid) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == WptrMax) begin
                            load_ovf <= 1'b1;
                        end
                        if (load_count != LoadMax) begin
                            load_count <= load_count + 1'b1;
                        end
                        if (ld_last) begin
                            state <= StIdle;
                        end
                    end
                end
                StRun: begin
                    if (halt) begin
                        state  <= StHalted;
                        issued <= 1'b0;
                    end else if (br_taken) begin
                        fetch_pc <= br_target;
                        issued   <= 1'b0;
                    end else if (!stall) begin
                        fetch_pc <= fetch_pc + 32'd1;
                        pc       <= fetch_pc;
                        issued   <= 1'b1;
                    end
                end
                StHalted: begin
                    // Only reset leaves this state.
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns / 1ps
// tb_fetch_controller
//
// Directed bench for fetch_controller. Two instances share all stimulus: one at
// the default address width and one with ADDR_W=2 to exercise write-pointer wrap.
// Each instance drives its own behavioural synchronous RAM. Expected memory
// writes and fetched instructions are queued when stimulus is driven and popped
// when the design produces them.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        start;
    logic        halt;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;

    logic        ld_ready1, mem_en1, mem_we1, instr_valid1, busy1, load_ovf1;
    logic [9:0]  mem_addr1;
    logic [31:0] mem_din1, mem_dout1, pc1, instr1;
    logic [10:0] load_count1;

    logic        ld_ready2, mem_en2, mem_we2, instr_valid2, busy2, load_ovf2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_din2, mem_dout2, pc2, instr2;
    logic [2:0]  load_count2;

    logic [31:0] mem1 [1024];
    logic [31:0] mem2 [4];

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fe_t;

    wr_t wr1_q[$];
    wr_t wr2_q[$];
    fe_t fe_q[$];
    wr_t e1, e2;

    logic [31:0] a_w [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};

    int total = 0;
    int bad   = 0;

    fetch_controller dut1 (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready1),
        .start      (start),
        .halt       (halt),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .mem_en     (mem_en1),
        .mem_we     (mem_we1),
        .mem_addr   (mem_addr1),
        .mem_din    (mem_din1),
        .mem_dout   (mem_dout1),
        .pc         (pc1),
        .instr      (instr1),
        .instr_valid(instr_valid1),
        .busy       (busy1),
        .load_count (load_count1),
        .load_ovf   (load_ovf1)
    );

    fetch_controller #(.ADDR_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready2),
        .start      (start),
        .halt       (halt),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .mem_en     (mem_en2),
        .mem_we     (mem_we2),
        .mem_addr   (mem_addr2),
        .mem_din    (mem_din2),
        .mem_dout   (mem_dout2),
        .pc         (pc2),
        .instr      (instr2),
        .instr_valid(instr_valid2),
        .busy       (busy2),
        .load_count (load_count2),
        .load_ovf   (load_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1) mem1[mem_addr1] <= mem_din1;
            else         mem_dout1 <= mem1[mem_addr1];
        end
        if (mem_en2) begin
            if (mem_we2) mem2[mem_addr2] <= mem_din2;
            else         mem_dout2 <= mem2[mem_addr2];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every memory write must match the next queued write.
    always @(posedge clk) begin
        if (mem_en1 && mem_we1) begin
            if (wr1_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL wr1_unexpected: observed write %0h@%0h expected none",
                       mem_din1, mem_addr1);
            end else begin
                e1 = wr1_q.pop_front();
                check("wr1_addr", 64'(mem_addr1), 64'(e1.addr));
                check("wr1_data", 64'(mem_din1), 64'(e1.data));
            end
        end
        if (mem_en2 && mem_we2) begin
            if (wr2_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL wr2_unexpected: observed write %0h@%0h expected none",
                       mem_din2, mem_addr2);
            end else begin
                e2 = wr2_q.pop_front();
                check("wr2_addr", 64'(mem_addr2), 64'(e2.addr));
                check("wr2_data", 64'(mem_din2), 64'(e2.data));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push_wr(input int i, input logic [31:0] d);
        wr1_q.push_back(wr_t'{addr: 10'(i), data: d});
        wr2_q.push_back(wr_t'{addr: 10'(i % 4), data: d});
    endtask

    task automatic issue(input logic [31:0] a);
        fe_q.push_back(fe_t'{pc: a, instr: a_w[a[1:0]]});
    endtask

    task automatic expect_fetch;
        fe_t e;
        if (fe_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL fetch_underflow: observed pc %0h expected no fetch", pc1);
        end else begin
            e = fe_q.pop_front();
            check("fetch_valid", 64'(instr_valid1), 64'd1);
            check("fetch_pc", 64'(pc1), 64'(e.pc));
            check("fetch_instr", 64'(instr1), 64'(e.instr));
        end
    endtask

    task automatic check_reset;
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_mem_en", 64'(mem_en1), 64'd0);
        check("rst_mem_we", 64'(mem_we1), 64'd0);
        check("rst_ld_ready", 64'(ld_ready1), 64'd0);
        check("rst_valid", 64'(instr_valid1), 64'd0);
        check("rst_pc", 64'(pc1), 64'd0);
        check("rst_count", 64'(load_count1), 64'd0);
        check("rst_ovf", 64'(load_ovf1), 64'd0);
    endtask

    initial begin
        rst = 1'b0; load_req = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        start = 1'b0; halt = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        #1 check_reset();
        tick; tick;
        rst = 1'b1;

        // Load A0..A3 with idle gaps between words.
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
        #1;
        check("load_busy", 64'(busy1), 64'd1);
        check("load_ready", 64'(ld_ready1), 64'd1);
        check("load_idle_en", 64'(mem_en1), 64'd0);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = a_w[i];
            ld_last  = (i == 3);
            push_wr(i, a_w[i]);
            #1;
            check("ld_we", 64'(mem_we1), 64'd1);
            check("ld_addr", 64'(mem_addr1), 64'(i));
            tick;
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (i < 3) begin
                #1 check("ld_gap_en", 64'(mem_en1), 64'd0);
                tick;
            end
        end
        #1;
        check("load_done_busy", 64'(busy1), 64'd0);
        check("load_done_ready", 64'(ld_ready1), 64'd0);
        check("load_count", 64'(load_count1), 64'd4);
        check("load_ovf", 64'(load_ovf1), 64'd0);
        check("load_count_w2", 64'(load_count2), 64'd4);

        // Sequential fetch, then a three-cycle stall at pc=1.
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        check("run_en", 64'(mem_en1), 64'd1);
        check("run_we", 64'(mem_we1), 64'd0);
        check("run_addr", 64'(mem_addr1), 64'd0);
        check("run_first_valid", 64'(instr_valid1), 64'd0);
        issue(0); tick; expect_fetch();
        issue(1); tick; expect_fetch();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_en", 64'(mem_en1), 64'd0);
            tick;
            check("stall_pc", 64'(pc1), 64'd1);
            check("stall_instr", 64'(instr1), 64'(a_w[1]));
            check("stall_valid", 64'(instr_valid1), 64'd1);
        end
        stall = 1'b0;
        issue(2); tick; expect_fetch();
        issue(3); tick; expect_fetch();

        // Halt outranks branch and stall; HALTED ignores start/load_req.
        halt = 1'b1; br_taken = 1'b1; stall = 1'b1; br_target = 32'd0;
        #1 check("halt_en", 64'(mem_en1), 64'd0);
        tick;
        halt = 1'b0; br_taken = 1'b0; stall = 1'b0; start = 1'b1; load_req = 1'b1;
        #1;
        check("halted_busy", 64'(busy1), 64'd1);
        check("halted_valid", 64'(instr_valid1), 64'd0);
        check("halted_en", 64'(mem_en1), 64'd0);
        tick;
        check("halted_stay_ready", 64'(ld_ready1), 64'd0);
        check("halted_stay_en", 64'(mem_en1), 64'd0);
        check("halted_stay_busy", 64'(busy1), 64'd1);
        start = 1'b0; load_req = 1'b0;

        // Reset out of HALTED, then a branch taken under stall.
        rst = 1'b0;
        #1 check_reset();
        tick;
        rst = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        issue(0); tick; expect_fetch();
        stall = 1'b1; br_taken = 1'b1; br_target = 32'd2;
        tick;
        stall = 1'b0; br_taken = 1'b0;
        #1 check("br_bubble_valid", 64'(instr_valid1), 64'd0);
        issue(2); tick; expect_fetch();
        issue(3); tick; expect_fetch();

        // Asynchronous reset between edges while fetching address 4.
        @(posedge clk);
        #2;
        check("pre_rst_valid", 64'(instr_valid1), 64'd1);
        check("pre_rst_pc", 64'(pc1), 64'd4);
        rst = 1'b0;
        #1;
        check("async_valid", 64'(instr_valid1), 64'd0);
        check("async_en", 64'(mem_en1), 64'd0);
        check("async_busy", 64'(busy1), 64'd0);
        check("async_pc", 64'(pc1), 64'd0);
        tick;
        rst = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        issue(0); tick; expect_fetch();

        // Five-word load: the ADDR_W=2 instance wraps and saturates.
        rst = 1'b0;
        tick;
        rst = 1'b1;
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hB000_0000 + 32'(i);
            ld_last  = (i == 4);
            push_wr(i, ld_data);
            tick;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check("ovf_count_w2", 64'(load_count2), 64'd4);
        check("ovf_flag_w2", 64'(load_ovf2), 64'd1);
        check("ovf_count_w10", 64'(load_count1), 64'd5);
        check("ovf_flag_w10", 64'(load_ovf1), 64'd0);
        check("ovf_idle", 64'(busy2), 64'd0);

        // Re-entering LOAD clears count, flag and write pointer.
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
        #1;
        check("reload_count_w2", 64'(load_count2), 64'd0);
        check("reload_ovf_w2", 64'(load_ovf2), 64'd0);
        ld_valid = 1'b1; ld_data = 32'hC000_00C0; ld_last = 1'b1;
        push_wr(0, ld_data);
        tick;
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("reload_done_w10", 64'(load_count1), 64'd1);
        check("reload_done_w2", 64'(load_count2), 64'd1);
        check("reload_ovf_after", 64'(load_ovf2), 64'd0);

        // Reset mid-LOAD with ld_valid held: no write may follow.
        load_req = 1'b1;
        tick;
        load_req = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hD000_00D0; ld_last = 1'b0;
        push_wr(0, ld_data);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ldrst_en", 64'(mem_en1), 64'd0);
        check("ldrst_we", 64'(mem_we1), 64'd0);
        check("ldrst_ready", 64'(ld_ready1), 64'd0);
        check("ldrst_en_w2", 64'(mem_en2), 64'd0);
        tick; tick;
        ld_valid = 1'b0;
        rst = 1'b1;
        tick;
        check("mem_kept_0", 64'(mem1[0]), 64'hD000_00D0);
        check("mem_kept_1", 64'(mem1[1]), 64'hB000_0001);
        check("wr1_drained", 64'(wr1_q.size()), 64'd0);
        check("wr2_drained", 64'(wr2_q.size()), 64'd0);
        check("fetch_drained", 64'(fe_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
